// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcodes, microstep indices and control-word layout for the sequencer.
package control_sequencer_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_STA  = 4'h4,
    OP_LDI  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_MVB  = 4'h9,
    OP_OUTB = 4'hA,
    OP_OUT  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;
  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  // Field order is the control-word bit order, HLT in bit 16 down to FI in bit 0.
  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic bi;
    logic bo;
    logic eo;
    logic su;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } control_word_t;
endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// microcode_rom: combinational decode of {opcode, step, cf, zf} into the 17-bit control word.
module microcode_rom
  import control_sequencer_pkg::*;
(
  input  logic [3:0]    i_opcode,
  input  logic [2:0]    i_step,
  input  logic          i_cf,
  input  logic          i_zf,
  output control_word_t o_cw
);
  always_comb begin
    o_cw = '0;
    if (i_step == T0) begin
      o_cw.mi = 1'b1;
      o_cw.co = 1'b1;
    end else if (i_step == T1) begin
      o_cw.ro = 1'b1;
      o_cw.ii = 1'b1;
      o_cw.ce = 1'b1;
    end else if (i_step == T2) begin
      case (i_opcode)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
          o_cw.io = 1'b1;
          o_cw.mi = 1'b1;
        end
        OP_LDI: begin
          o_cw.io = 1'b1;
          o_cw.ai = 1'b1;
        end
        OP_JMP: begin
          o_cw.io = 1'b1;
          o_cw.j  = 1'b1;
        end
        OP_JC: begin
          o_cw.io = i_cf;
          o_cw.j  = i_cf;
        end
        OP_JZ: begin
          o_cw.io = i_zf;
          o_cw.j  = i_zf;
        end
        OP_MVB: begin
          o_cw.ao = 1'b1;
          o_cw.bi = 1'b1;
        end
        OP_OUTB: begin
          o_cw.bo = 1'b1;
          o_cw.oi = 1'b1;
        end
        OP_OUT: begin
          o_cw.ao = 1'b1;
          o_cw.oi = 1'b1;
        end
        OP_HLT: o_cw.hlt = 1'b1;
        default: ;
      endcase
    end else if (i_step == T3) begin
      case (i_opcode)
        OP_LDA: begin
          o_cw.ro = 1'b1;
          o_cw.ai = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          o_cw.ro = 1'b1;
          o_cw.bi = 1'b1;
        end
        OP_STA: begin
          o_cw.ao = 1'b1;
          o_cw.ri = 1'b1;
        end
        default: ;
      endcase
    end else if (i_step == T4) begin
      o_cw.eo = (i_opcode == OP_ADD) || (i_opcode == OP_SUB);
      o_cw.ai = o_cw.eo;
      o_cw.fi = o_cw.eo;
      o_cw.su = (i_opcode == OP_SUB);
    end
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: instruction/flag/step registers, microcode decode and bus drive for the 8-bit computer.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int STEP_COUNT = 5
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus,
  input  logic       carry,
  input  logic       zero,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       BI,
  output logic       BO,
  output logic       EO,
  output logic       SU,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI,
  output logic [2:0] step,
  output logic       halted
);
  logic [7:0]    r_ir;
  logic          r_cf;
  logic          r_zf;
  logic [2:0]    r_step;
  logic          r_halted;
  control_word_t w_rom_cw;
  control_word_t w_cw;
  microcode_rom u_rom (
    .i_opcode(r_ir[7:4]),
    .i_step  (r_step),
    .i_cf    (r_cf),
    .i_zf    (r_zf),
    .o_cw    (w_rom_cw)
  );
  // Reset and halt silence every strobe combinationally so peripherals see nothing on the next edge.
  assign w_cw = (rst || r_halted) ? '0 : w_rom_cw;
  assign {HLT, MI, RI, RO, IO, II, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI} = w_cw;
  assign bus = w_cw.io ? {4'b0000, r_ir[3:0]} : 8'bz;
  assign step = r_step;
  assign halted = r_halted;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir     <= '0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      r_step <= (r_step == 3'(STEP_COUNT - 1)) ? '0 : r_step + 3'd1;
      if (w_cw.ii) r_ir <= bus;
      if (w_cw.fi) begin
        r_cf <= carry;
        r_zf <= zero;
      end
      if (w_cw.hlt) r_halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: drives the sequencer inside a small RAM/PC/A/B/ALU model and scores its control words.
module tb_control_sequencer;
  localparam logic [16:0] K_HLT = 17'h10000, K_MI = 17'h08000, K_RI = 17'h04000, K_RO = 17'h02000;
  localparam logic [16:0] K_IO  = 17'h01000, K_II = 17'h00800, K_AI = 17'h00400, K_AO = 17'h00200;
  localparam logic [16:0] K_BI  = 17'h00100, K_BO = 17'h00080, K_EO = 17'h00040, K_SU = 17'h00020;
  localparam logic [16:0] K_OI  = 17'h00010, K_CE = 17'h00008, K_CO = 17'h00004, K_J  = 17'h00002;
  localparam logic [16:0] K_FI  = 17'h00001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic carry, zero;
  wire  [7:0] bus;
  logic HLT, MI, RI, RO, IO, II, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI;
  logic [2:0] step;
  logic halted;
  logic [16:0] cw;
  logic [7:0] prog [16];
  logic [7:0] ram [16];
  logic [3:0] mar, pc;
  logic [7:0] a, b;
  logic [8:0] sum;
  control_sequencer dut (
    .clk(clk), .rst(rst), .bus(bus), .carry(carry), .zero(zero),
    .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .IO(IO), .II(II), .AI(AI), .AO(AO), .BI(BI),
    .BO(BO), .EO(EO), .SU(SU), .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI),
    .step(step), .halted(halted)
  );
  always #5 clk = ~clk;
  assign cw = {HLT, MI, RI, RO, IO, II, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI};
  always_comb begin
    sum   = {1'b0, a} + {1'b0, SU ? ~b : b} + {8'd0, SU};
    carry = sum[8];
    zero  = (sum[7:0] == 8'd0);
  end
  assign bus = (RO | CO | AO | BO | EO) ?
               (RO ? ram[mar] : CO ? {4'b0000, pc} : AO ? a : BO ? b : sum[7:0]) : 8'bz;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= prog[i];
      mar <= '0;
      pc  <= '0;
      a   <= '0;
      b   <= '0;
    end else begin
      if (MI) mar <= bus[3:0];
      if (RI) ram[mar] <= bus;
      if (AI) a <= bus;
      if (BI) b <= bus;
      if (J) pc <= bus[3:0];
      else if (CE) pc <= pc + 4'd1;
    end
  end
  typedef struct {
    string       nm;
    logic [2:0]  step;
    logic [16:0] cw;
    logic        halted;
    logic [7:0]  bus;
  } exp_t;
  typedef struct {
    string       nm;
    logic [7:0]  instr;
    logic [16:0] t2, t3, t4;
  } vec_t;
  exp_t sbq[$];
  vec_t vecs[15];
  int tests = 0;
  int failed = 0;
  task automatic cmp(input string nm, input logic [16:0] act, input logic [16:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push_one(input string nm, input logic [2:0] s, input logic [16:0] w, input logic h, input logic [3:0] opnd);
    exp_t e;
    e.nm = $sformatf("%s_t%0d", nm, s);
    e.step = s;
    e.cw = w;
    e.halted = h;
    e.bus = {4'b0000, opnd};
    sbq.push_back(e);
  endtask
  task automatic push_instr(input string nm, input logic [7:0] instr, input logic [16:0] t2, input logic [16:0] t3, input logic [16:0] t4, input int n);
    logic [16:0] w [5];
    w = '{K_MI | K_CO, K_RO | K_II | K_CE, t2, t3, t4};
    for (int s = 0; s < n; s++) push_one(nm, 3'(s), w[s], 1'b0, instr[3:0]);
  endtask
  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      #1;
      if (sbq.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_underflow: got empty queue expected entry");
      end else begin
        e = sbq.pop_front();
        cmp({e.nm, "_cw"}, cw, e.cw);
        cmp({e.nm, "_step"}, 17'(step), 17'(e.step));
        cmp({e.nm, "_halted"}, 17'(halted), 17'(e.halted));
        if (e.cw[12]) cmp({e.nm, "_bus"}, 17'(bus), 17'(e.bus));
      end
      @(negedge clk);
    end
  endtask
  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    cmp({nm, "_rst_gate"}, cw, 17'd0);
    repeat (2) @(negedge clk);
    #1;
    cmp({nm, "_rst_cw"}, cw, 17'd0);
    cmp({nm, "_rst_step"}, 17'(step), 17'd0);
    cmp({nm, "_rst_halted"}, 17'(halted), 17'd0);
    rst = 1'b0;
  endtask
  task automatic load(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] d14, input logic [7:0] d15);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = p0;
    prog[1] = p1;
    prog[2] = p2;
    prog[13] = 8'h11;
    prog[14] = d14;
    prog[15] = d15;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs = '{
      '{"lda",  8'h1E, K_IO | K_MI, K_RO | K_AI, 17'd0},
      '{"add",  8'h2F, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI},
      '{"sub",  8'h3F, K_IO | K_MI, K_RO | K_BI, K_EO | K_SU | K_AI | K_FI},
      '{"sta",  8'h4D, K_IO | K_MI, K_AO | K_RI, 17'd0},
      '{"ldi",  8'h55, K_IO | K_AI, 17'd0, 17'd0},
      '{"jmp",  8'h63, K_IO | K_J, 17'd0, 17'd0},
      '{"jc0",  8'h73, 17'd0, 17'd0, 17'd0},
      '{"jz0",  8'h83, 17'd0, 17'd0, 17'd0},
      '{"mvb",  8'h90, K_AO | K_BI, 17'd0, 17'd0},
      '{"outb", 8'hA0, K_BO | K_OI, 17'd0, 17'd0},
      '{"out",  8'hE0, K_AO | K_OI, 17'd0, 17'd0},
      '{"nop",  8'h00, 17'd0, 17'd0, 17'd0},
      '{"opb",  8'hB7, 17'd0, 17'd0, 17'd0},
      '{"opc",  8'hC7, 17'd0, 17'd0, 17'd0},
      '{"opd",  8'hD7, 17'd0, 17'd0, 17'd0}
    };
    for (int v = 0; v < 15; v++) begin
      load(vecs[v].instr, 8'h00, 8'h00, 8'h07, 8'h01);
      do_reset(vecs[v].nm);
      push_instr(vecs[v].nm, vecs[v].instr, vecs[v].t2, vecs[v].t3, vecs[v].t4, 5);
      run(5);
    end
    // 0xFF + 0x01 carries out and wraps to zero, so both conditional jumps must be taken.
    load(8'h1E, 8'h2F, 8'h75, 8'hFF, 8'h01);
    prog[5] = 8'h87;
    do_reset("addf");
    push_instr("addf_lda", 8'h1E, K_IO | K_MI, K_RO | K_AI, 17'd0, 5);
    push_instr("addf_add", 8'h2F, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI, 5);
    push_instr("addf_jc1", 8'h75, K_IO | K_J, 17'd0, 17'd0, 5);
    push_instr("addf_jz1", 8'h87, K_IO | K_J, 17'd0, 17'd0, 5);
    run(20);
    load(8'h1E, 8'h3F, 8'h74, 8'h05, 8'h05);
    prog[4] = 8'h86;
    do_reset("subf");
    push_instr("subf_lda", 8'h1E, K_IO | K_MI, K_RO | K_AI, 17'd0, 5);
    push_instr("subf_sub", 8'h3F, K_IO | K_MI, K_RO | K_BI, K_EO | K_SU | K_AI | K_FI, 5);
    push_instr("subf_jc1", 8'h74, K_IO | K_J, 17'd0, 17'd0, 5);
    push_instr("subf_jz1", 8'h86, K_IO | K_J, 17'd0, 17'd0, 5);
    run(20);
    load(8'hF0, 8'h1E, 8'h00, 8'h07, 8'h01);
    do_reset("hlt");
    push_instr("hlt", 8'hF0, K_HLT, 17'd0, 17'd0, 3);
    for (int i = 0; i < 20; i++) push_one("hlt_frozen", 3'd3, 17'd0, 1'b1, 4'h0);
    run(23);
    do_reset("hlt_clr");
    push_instr("hlt_refetch", 8'hF0, K_HLT, 17'd0, 17'd0, 2);
    run(2);
    load(8'h1E, 8'h3F, 8'h2F, 8'h05, 8'h05);
    do_reset("abort");
    push_instr("abort_lda", 8'h1E, K_IO | K_MI, K_RO | K_AI, 17'd0, 5);
    push_instr("abort_sub", 8'h3F, K_IO | K_MI, K_RO | K_BI, K_EO | K_SU | K_AI | K_FI, 5);
    push_instr("abort_add", 8'h2F, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI, 3);
    run(13);
    // Flags were set by the SUB; after the abort both jumps must fall through.
    load(8'h73, 8'h83, 8'h00, 8'h05, 8'h05);
    do_reset("abort_t3");
    push_instr("abort_jc0", 8'h73, 17'd0, 17'd0, 17'd0, 5);
    push_instr("abort_jz0", 8'h83, 17'd0, 17'd0, 17'd0, 5);
    run(10);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
